// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Digit code the font stage renders as all segments off.
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // 10^n as a constant function, used for the parameter legality check.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Largest input is 9, so 9+3 = 12 fits in four bits without carry.
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with optional leading-zero blanking for the seven-segment font stage.
//
// Handshake: start is a request that is honoured only while the FSM is in
// IDLE (dbg_state == IDLE); bin_in is captured on the accepting edge. A
// request seen in any other state is dropped, not queued. busy is high from
// the edge after acceptance up to and including the done cycle; done is a
// one-cycle pulse coinciding with the bcd_out update.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic [1:0]              dbg_state
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Reject parameter sets that cannot hold every input value.
  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W must be in 4..32");
  end
  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               done_q;
  logic               busy_q;

  logic [SCR_W-1:0]       adj_w;
  logic [SCR_W+BIN_W-1:0] shifted_w;
  logic [SCR_W-1:0]       blank_w;

  // Per-digit add-3 correction on the scratch register.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch_q[gi*BCD_W +: BCD_W]),
      .dout (adj_w[gi*BCD_W +: BCD_W])
    );
  end

  // One double-dabble step: corrected scratch and the binary shift register
  // move left together; the bit leaving the scratch MSB is always zero.
  assign shifted_w = {adj_w, shift_q} << 1;

  // Units digit always passes through, so a zero value shows as "0".
  assign blank_w[BCD_W-1:0] = scratch_q[BCD_W-1:0];

  if (BLANK_LZ != 0) begin : g_lz
    // Each digit above units is kept if it or any higher digit is non-zero.
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_dig
      logic [BCD_W-1:0] dig;
      logic             seen;
      assign dig = scratch_q[gi*BCD_W +: BCD_W];
      if (gi == DIGITS - 1) begin : g_msb
        assign seen = |dig;
      end else begin : g_low
        assign seen = (|dig) | g_dig[gi+1].seen;
      end
      assign blank_w[gi*BCD_W +: BCD_W] = seen ? dig : BCD_BLANK;
    end
  end else begin : g_plain
    assign blank_w[SCR_W-1:BCD_W] = scratch_q[SCR_W-1:BCD_W];
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SHIFT runs exactly BIN_W cycles, FINISH one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch_q <= shifted_w[SCR_W+BIN_W-1:BIN_W];
          shift_q   <= shifted_w[BIN_W-1:0];
          cnt_q     <= cnt_q - CNT_W'(1);
        end
        FINISH: begin
          bcd_q  <= blank_w;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign dbg_state = state_q;

endmodule
